// File: rtl/mult_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : mult_seq_pkg
// Brief   : Shared types and constants for the mult_seq_ctrl sequencer.
// Rev     : 1.0 - initial release
// ============================================================================
package mult_seq_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        MUL   = 2'd1,
        STORE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int BYTES_PER_PAIR  = 4;
    localparam int BYTES_PER_PROD  = 4;
    localparam int MUL_STEPS       = 16;
    localparam int CYCLES_PER_PAIR = BYTES_PER_PAIR + MUL_STEPS + BYTES_PER_PROD;

    // Products leave the block big-endian: index 0 selects the MSB.
    function automatic logic [7:0] prod_byte(input logic [31:0] p, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = p[31:24];
            2'd1:    b = p[23:16];
            2'd2:    b = p[15:8];
            default: b = p[7:0];
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_mul16.sv
`default_nettype none
// ============================================================================
// Module : booth_mul16
// Brief  : Iterative radix-2 Booth multiplier, signed 16x16 -> 32, 16 steps.
// Rev    : 1.0 - initial release
// ============================================================================
module booth_mul16
    import mult_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [31:0] P,
    output logic        valid
);

    // 17-bit accumulator so that A = -32768 can be subtracted without overflow.
    logic [16:0] r_acc;
    logic [15:0] r_q;
    logic        r_qm1;
    logic [15:0] r_a;
    logic [3:0]  r_step;
    logic        r_active;
    logic        r_valid;

    logic [16:0] w_a_ext;
    logic [16:0] w_sum;

    always_comb begin
        w_a_ext = {r_a[15], r_a};
        case ({r_q[0], r_qm1})
            2'b01:   w_sum = r_acc + w_a_ext;
            2'b10:   w_sum = r_acc - w_a_ext;
            default: w_sum = r_acc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_q      <= '0;
            r_qm1    <= 1'b0;
            r_a      <= '0;
            r_step   <= '0;
            r_active <= 1'b0;
            r_valid  <= 1'b0;
        end else if (load) begin
            r_acc    <= '0;
            r_q      <= B;
            r_qm1    <= 1'b0;
            r_a      <= A;
            r_step   <= '0;
            r_active <= 1'b1;
            r_valid  <= 1'b0;
        end else if (r_active) begin
            r_acc  <= {w_sum[16], w_sum[16:1]};
            r_q    <= {w_sum[0], r_q[15:1]};
            r_qm1  <= r_q[0];
            r_step <= r_step + 4'd1;
            if (r_step == 4'(MUL_STEPS - 1)) begin
                r_active <= 1'b0;
                r_valid  <= 1'b1;
            end
        end
    end

    assign P     = {r_acc[15:0], r_q};
    assign valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mult_seq_ctrl
// Brief  : Data-memory master that multiplies NUM_PAIRS signed operand pairs.
// Rev    : 1.0 - initial release
// ============================================================================
module mult_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int NUM_PAIRS = 16,
    parameter int SRC_BASE  = 0,
    parameter int DST_BASE  = 64,
    parameter int AW        = 8
)(
    input  logic          clk,
    input  logic          reset,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data,
    output logic          busy,
    output logic          done
);

    localparam int c_pair_w = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;

    state_t              r_state;
    state_t              w_next_state;
    logic [c_pair_w-1:0] r_pair_idx;
    logic [1:0]          r_byte_cnt;
    logic [3:0]          r_iter_cnt;
    logic [7:0]          r_a_hi;
    logic [7:0]          r_a_lo;
    logic [7:0]          r_b_hi;

    logic                w_last_byte;
    logic                w_last_iter;
    logic                w_last_pair;
    logic                w_mul_load;
    logic [31:0]         w_prod;
    logic                w_prod_valid;
    logic [AW-1:0]       w_src_addr;
    logic [AW-1:0]       w_dst_addr;

    assign w_last_byte = (r_byte_cnt == 2'd3);
    assign w_last_iter = (r_iter_cnt == 4'(MUL_STEPS - 1));
    assign w_last_pair = (r_pair_idx == c_pair_w'(NUM_PAIRS - 1));

    // 4*pair + byte is just the two indices concatenated.
    assign w_src_addr = AW'(SRC_BASE) + AW'({r_pair_idx, r_byte_cnt});
    assign w_dst_addr = AW'(DST_BASE) + AW'({r_pair_idx, r_byte_cnt});

    // B_lo goes straight from the memory bus into the multiplier.
    assign w_mul_load = (r_state == LOAD) && w_last_byte;

    booth_mul16 u_booth (
        .clk   (clk),
        .reset (reset),
        .load  (w_mul_load),
        .A     ({r_a_hi, r_a_lo}),
        .B     ({r_b_hi, mem_rd_data}),
        .P     (w_prod),
        .valid (w_prod_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            LOAD:    if (w_last_byte) w_next_state = MUL;
            MUL:     if (w_last_iter) w_next_state = STORE;
            STORE:   if (w_last_byte) w_next_state = w_last_pair ? DONE : LOAD;
            default: w_next_state = DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pair_idx <= '0;
            r_byte_cnt <= '0;
            r_iter_cnt <= '0;
            r_a_hi     <= '0;
            r_a_lo     <= '0;
            r_b_hi     <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                    case (r_byte_cnt)
                        2'd0:    r_a_hi <= mem_rd_data;
                        2'd1:    r_a_lo <= mem_rd_data;
                        2'd2:    r_b_hi <= mem_rd_data;
                        default: ;
                    endcase
                end
                MUL: r_iter_cnt <= r_iter_cnt + 4'd1;
                STORE: begin
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                    if (w_last_byte && !w_last_pair) begin
                        r_pair_idx <= r_pair_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_addr    = w_src_addr;
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'h00;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            LOAD, MUL: busy = 1'b1;
            STORE: begin
                busy        = 1'b1;
                mem_addr    = w_dst_addr;
                mem_wr_en   = w_prod_valid;
                mem_wr_data = prod_byte(w_prod, r_byte_cnt);
            end
            default: begin
                mem_addr = AW'(DST_BASE);
                done     = 1'b1;
            end
        endcase
        // A reset sampled this cycle must not let a write or busy escape.
        if (reset) begin
            busy        = 1'b0;
            mem_wr_en   = 1'b0;
            mem_wr_data = 8'h00;
        end
    end

endmodule
`default_nettype wire
